mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, max cycles a granted transfer waits for s_mem_ready before forced completion.
REQ-002 Parameter ERR_RDATA, default 32'h00000000, read data returned to a master on timeout.
REQ-003 clk  input  1  single clock, all state on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 m0_mem_valid/m0_mem_instr  input  1 each  master 0 request / instruction-fetch flag (PicoRV32 native).
REQ-006 m0_mem_addr/m0_mem_wdata  input  32 each; m0_mem_wstrb  input  4  master 0 address, write data, byte strobes.
REQ-007 m0_mem_ready  output  1; m0_mem_rdata  output  32  master 0 completion and read data.
REQ-008 m1_mem_* ports  same directions and widths as REQ-005..007  master 1 (loader/debug port).
REQ-009 s_mem_valid/s_mem_instr  output  1 each; s_mem_addr/s_mem_wdata  output  32; s_mem_wstrb  output  4  shared memory side.
REQ-010 s_mem_ready  input  1; s_mem_rdata  input  32  shared memory completion and read data.
REQ-011 bus_error  output  1  one-cycle pulse on timeout completion.

Function
REQ-012 States IDLE, GRANT0, GRANT1; state register updates only on posedge clk.
REQ-013 IDLE: only m0_mem_valid -> GRANT0; only m1_mem_valid -> GRANT1; both -> master not recorded in last_grant; neither -> stay IDLE.
REQ-014 Request sampled in cycle N yields s_mem_valid=1 from cycle N+1 (one-cycle arbitration latency).
REQ-015 In GRANTk, s_mem_valid/instr/addr/wdata/wstrb equal master k's inputs combinationally; in IDLE all are 0.
REQ-016 In GRANTk, mk_mem_ready = s_mem_ready and mk_mem_rdata = s_mem_rdata combinationally; the other master sees ready=0, rdata=0.
REQ-017 On s_mem_ready=1 in GRANTk: last_grant<=k, state<=IDLE; IDLE always lasts at least one cycle between grants.
REQ-018 Grant is locked: a competing valid never preempts an active GRANTk.
REQ-019 If granted master drops valid without ready (protocol violation), transfer aborts: state<=IDLE, last_grant unchanged, no bus_error.
REQ-020 Wait counter, width clog2(TIMEOUT)+1, clears on entry to GRANTk, increments each GRANTk cycle without s_mem_ready.
REQ-021 Counter == TIMEOUT-1 with s_mem_ready=0: mk_mem_ready=1, mk_mem_rdata=ERR_RDATA, bus_error=1 same cycle, last_grant<=k, state<=IDLE.
REQ-022 s_mem_ready and timeout in same cycle: normal completion wins, s_mem_rdata delivered, bus_error=0.
REQ-023 s_mem_ready while IDLE is ignored; no master ready asserted.
REQ-024 Write vs read not distinguished by arbiter; wstrb passes through unchanged.

Reset
REQ-025 reset_n=0 at posedge: state=IDLE, last_grant=1 (m0 wins first tie), counter=0.
REQ-026 During and after reset: all s_mem_* outputs 0, m0/m1 ready 0, rdata 0, bus_error 0.
REQ-027 Reset mid-transfer abandons the grant without completion to either master; memory side sees s_mem_valid drop next cycle.

Structure
REQ-028 Shared package mem_arb_pkg holds state enum arb_state_t, master-id type, TIMEOUT and ERR_RDATA defaults.
REQ-029 Single sub-module mem_arb_timer (wait counter with clear/enable, expired output); muxing and FSM stay in mem_arbiter.

Verification
REQ-030 m0 read addr 0x100, memory ready after 2 cycles with 0x12345678 -> s_mem_valid cycle N+1, m0_mem_ready once with 0x12345678, m1 ready 0.
REQ-031 m0 and m1 valid same cycle after reset -> m0 served first, then one IDLE cycle, then m1; repeat -> m1 order alternates fairly.
REQ-032 m1 write addr 0x200 wdata 0xCAFEBABE wstrb 1111 -> s_mem_* mirror exactly, m0 issuing mid-transfer waits until m1 completes.
REQ-033 TIMEOUT=8, memory never ready -> after 8 grant cycles master ready=1, rdata=0, bus_error pulse 1 cycle, next request still served.
REQ-034 reset_n=0 during GRANT1 -> next cycle all outputs 0, state IDLE; subsequent simultaneous request grants m0.
REQ-035 Ready on exact timeout cycle with 0xA5A5A5A5 -> rdata 0xA5A5A5A5, bus_error 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master PicoRV32 memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t MID_M0 = 1'b0;
    localparam master_id_t MID_M1 = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT   = 1024;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter for a granted transfer; flags the last allowed cycle.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expired marks the cycle in which a still-unanswered transfer is forced to complete.
    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one PicoRV32-native memory port,
// with locked grants and a timeout that completes stalled transfers with an error.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,

    output logic        bus_error
);

    arb_state_t state_q;
    master_id_t last_grant_q;

    logic gnt0;
    logic gnt1;
    logic granted;
    logic sel_valid;
    logic timer_expired;
    logic timeout_hit;
    logic abort;

    assign gnt0      = (state_q == ST_GRANT0);
    assign gnt1      = (state_q == ST_GRANT1);
    assign granted   = gnt0 | gnt1;
    assign sel_valid = (gnt0 & m0_mem_valid) | (gnt1 & m1_mem_valid);

    // A real ready always wins over the timeout; a dropped valid aborts silently.
    assign timeout_hit = granted & sel_valid & ~s_mem_ready & timer_expired;
    assign abort       = granted & ~sel_valid & ~s_mem_ready;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .clr_i     (state_q == ST_IDLE),
        .en_i      (granted & ~s_mem_ready),
        .expired_o (timer_expired)
    );

    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wdata  = '0;
        s_mem_wstrb  = '0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        bus_error    = timeout_hit;
        case (state_q)
            ST_GRANT0: begin
                s_mem_valid  = m0_mem_valid;
                s_mem_instr  = m0_mem_instr;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                s_mem_wstrb  = m0_mem_wstrb;
                m0_mem_ready = s_mem_ready | timeout_hit;
                m0_mem_rdata = timeout_hit ? ERR_RDATA : s_mem_rdata;
            end
            ST_GRANT1: begin
                s_mem_valid  = m1_mem_valid;
                s_mem_instr  = m1_mem_instr;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                s_mem_wstrb  = m1_mem_wstrb;
                m1_mem_ready = s_mem_ready | timeout_hit;
                m1_mem_rdata = timeout_hit ? ERR_RDATA : s_mem_rdata;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= MID_M1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_mem_valid && m1_mem_valid) begin
                        state_q <= (last_grant_q == MID_M1) ? ST_GRANT0 : ST_GRANT1;
                    end else if (m0_mem_valid) begin
                        state_q <= ST_GRANT0;
                    end else if (m1_mem_valid) begin
                        state_q <= ST_GRANT1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (s_mem_ready || timeout_hit) begin
                        last_grant_q <= gnt1 ? MID_M1 : MID_M0;
                        state_q      <= ST_IDLE;
                    end else if (abort) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus timeout and reset sequences.
module tb_mem_arbiter;

    localparam logic [31:0] A0  = 32'h0000_0100;
    localparam logic [31:0] A1  = 32'h0000_0200;
    localparam logic [31:0] WD1 = 32'hCAFE_BABE;
    localparam logic [31:0] ERR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0v = 1'b0, m1v = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        srdy = 1'b0;
    logic [31:0] srd = 32'h0;
    logic        berr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_mem_valid (m0v),
        .m0_mem_instr (1'b1),
        .m0_mem_addr  (A0),
        .m0_mem_wdata (32'h0),
        .m0_mem_wstrb (4'h0),
        .m0_mem_ready (m0_ready),
        .m0_mem_rdata (m0_rdata),
        .m1_mem_valid (m1v),
        .m1_mem_instr (1'b0),
        .m1_mem_addr  (A1),
        .m1_mem_wdata (WD1),
        .m1_mem_wstrb (4'hF),
        .m1_mem_ready (m1_ready),
        .m1_mem_rdata (m1_rdata),
        .s_mem_valid  (s_valid),
        .s_mem_instr  (s_instr),
        .s_mem_addr   (s_addr),
        .s_mem_wdata  (s_wdata),
        .s_mem_wstrb  (s_wstrb),
        .s_mem_ready  (srdy),
        .s_mem_rdata  (srd),
        .bus_error    (berr)
    );

    typedef struct {
        logic        m0v, m1v, srdy;
        logic [31:0] srd;
        logic        esv;
        logic [31:0] esa, eswd;
        logic [3:0]  esws;
        logic        esi, em0r;
        logic [31:0] em0d;
        logic        em1r;
        logic [31:0] em1d;
        logic        ebe;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic i0, logic i1, logic ir, logic [31:0] id,
                                logic sv, logic [31:0] sa, logic [31:0] swd, logic [3:0] sws, logic si,
                                logic r0, logic [31:0] d0, logic r1, logic [31:0] d1, logic be);
        vec_t v;
        v.m0v = i0; v.m1v = i1; v.srdy = ir; v.srd = id;
        v.esv = sv; v.esa = sa; v.eswd = swd; v.esws = sws; v.esi = si;
        v.em0r = r0; v.em0d = d0; v.em1r = r1; v.em1d = d1; v.ebe = be;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".s_valid"}, 32'(s_valid), 32'd0);
        chk({tag, ".s_addr"}, s_addr, 32'd0);
        chk({tag, ".s_wdata"}, s_wdata, 32'd0);
        chk({tag, ".s_wstrb"}, 32'(s_wstrb), 32'd0);
        chk({tag, ".m0_ready"}, 32'(m0_ready), 32'd0);
        chk({tag, ".m1_ready"}, 32'(m1_ready), 32'd0);
        chk({tag, ".m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, ".m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, ".bus_error"}, 32'(berr), 32'd0);
    endtask

    initial begin
        // read, tie-break alternation, locked grant, abort without bus_error
        tbl[0]  = mk(1,0,0,32'h0,        0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);
        tbl[1]  = mk(1,0,0,32'hDEAD0001, 1,A0,0  ,4'h0,1, 0,32'hDEAD0001, 0,32'h0,        0);
        tbl[2]  = mk(1,0,0,32'h0,        1,A0,0  ,4'h0,1, 0,32'h0,        0,32'h0,        0);
        tbl[3]  = mk(1,0,1,32'h12345678, 1,A0,0  ,4'h0,1, 1,32'h12345678, 0,32'h0,        0);
        tbl[4]  = mk(0,0,1,32'h99990000, 0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);
        tbl[5]  = mk(1,1,0,32'h0,        0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);
        tbl[6]  = mk(1,1,1,32'hBEEF0001, 1,A1,WD1,4'hF,0, 0,32'h0,        1,32'hBEEF0001, 0);
        tbl[7]  = mk(1,1,0,32'h0,        0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);
        tbl[8]  = mk(1,1,1,32'h11112222, 1,A0,0  ,4'h0,1, 1,32'h11112222, 0,32'h0,        0);
        tbl[9]  = mk(1,1,0,32'h0,        0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);
        tbl[10] = mk(1,1,0,32'h0,        1,A1,WD1,4'hF,0, 0,32'h0,        0,32'h0,        0);
        tbl[11] = mk(1,1,1,32'h33334444, 1,A1,WD1,4'hF,0, 0,32'h0,        1,32'h33334444, 0);
        tbl[12] = mk(1,0,0,32'h0,        0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);
        tbl[13] = mk(0,0,0,32'h0,        0,A0,0  ,4'h0,1, 0,32'h0,        0,32'h0,        0);
        tbl[14] = mk(1,1,0,32'h0,        0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);
        tbl[15] = mk(1,1,1,32'h55556666, 1,A0,0  ,4'h0,1, 1,32'h55556666, 0,32'h0,        0);
        tbl[16] = mk(0,0,0,32'h0,        0,0 ,0  ,4'h0,0, 0,32'h0,        0,32'h0,        0);

        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        reset_n = 1'b1;
        #3;
        chk_quiet("post_reset");

        for (int i = 0; i < 17; i++) begin
            cyc();
            m0v = tbl[i].m0v; m1v = tbl[i].m1v; srdy = tbl[i].srdy; srd = tbl[i].srd;
            #3;
            chk($sformatf("v%0d.s_valid", i),   32'(s_valid),  32'(tbl[i].esv));
            chk($sformatf("v%0d.s_addr", i),    s_addr,        tbl[i].esa);
            chk($sformatf("v%0d.s_wdata", i),   s_wdata,       tbl[i].eswd);
            chk($sformatf("v%0d.s_wstrb", i),   32'(s_wstrb),  32'(tbl[i].esws));
            chk($sformatf("v%0d.s_instr", i),   32'(s_instr),  32'(tbl[i].esi));
            chk($sformatf("v%0d.m0_ready", i),  32'(m0_ready), 32'(tbl[i].em0r));
            chk($sformatf("v%0d.m0_rdata", i),  m0_rdata,      tbl[i].em0d);
            chk($sformatf("v%0d.m1_ready", i),  32'(m1_ready), 32'(tbl[i].em1r));
            chk($sformatf("v%0d.m1_rdata", i),  m1_rdata,      tbl[i].em1d);
            chk($sformatf("v%0d.bus_error", i), 32'(berr),     32'(tbl[i].ebe));
        end

        // m1 stalls: the eighth grant cycle completes with ERR and a bus_error pulse
        cyc(); m0v = 0; m1v = 1; srdy = 0; srd = 32'hDEAD0000;
        #3; chk("to.idle.s_valid", 32'(s_valid), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            #3;
            chk($sformatf("to.c%0d.s_valid", i),   32'(s_valid),  32'd1);
            chk($sformatf("to.c%0d.m1_ready", i),  32'(m1_ready), (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("to.c%0d.m1_rdata", i),  m1_rdata,      (i == 8) ? ERR : 32'hDEAD0000);
            chk($sformatf("to.c%0d.bus_error", i), 32'(berr),     (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("to.c%0d.m0_ready", i),  32'(m0_ready), 32'd0);
        end
        cyc(); #3;
        chk("to.after.s_valid", 32'(s_valid), 32'd0);
        chk("to.after.bus_error", 32'(berr), 32'd0);
        chk("to.after.m1_ready", 32'(m1_ready), 32'd0);
        cyc(); srdy = 1; srd = 32'h77778888;
        #3;
        chk("to.retry.s_addr", s_addr, A1);
        chk("to.retry.m1_ready", 32'(m1_ready), 32'd1);
        chk("to.retry.m1_rdata", m1_rdata, 32'h77778888);
        chk("to.retry.bus_error", 32'(berr), 32'd0);
        cyc(); m1v = 0; srdy = 0; srd = 32'h0;
        #3; chk("to.end.s_valid", 32'(s_valid), 32'd0);

        // ready arrives on the exact timeout cycle: real data, no error
        cyc(); m0v = 1;
        #3; chk("ex.idle.s_valid", 32'(s_valid), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            srdy = (i == 8);
            srd  = (i == 8) ? 32'hA5A5A5A5 : 32'h0;
            #3;
            chk($sformatf("ex.c%0d.m0_ready", i),  32'(m0_ready), (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("ex.c%0d.m0_rdata", i),  m0_rdata,      (i == 8) ? 32'hA5A5A5A5 : 32'h0);
            chk($sformatf("ex.c%0d.bus_error", i), 32'(berr),     32'd0);
        end
        cyc(); m0v = 0; srdy = 0; srd = 32'h0;
        #3; chk("ex.end.s_valid", 32'(s_valid), 32'd0);

        // reset during GRANT1, then a tie must go to m0
        cyc(); m1v = 1;
        #3; chk("rs.idle.s_valid", 32'(s_valid), 32'd0);
        cyc(); #3;
        chk("rs.g1.s_valid", 32'(s_valid), 32'd1);
        chk("rs.g1.s_addr", s_addr, A1);
        reset_n = 1'b0;
        cyc(); m0v = 1; srdy = 1; srd = 32'h12121212;
        #3;
        chk_quiet("rs.in_reset");
        reset_n = 1'b1; srdy = 0; srd = 32'h0;
        cyc(); #3;
        chk("rs.tie.s_valid", 32'(s_valid), 32'd1);
        chk("rs.tie.s_addr", s_addr, A0);
        chk("rs.tie.s_instr", 32'(s_instr), 32'd1);
        cyc(); srdy = 1; srd = 32'h0BADF00D;
        #3;
        chk("rs.tie.m0_ready", 32'(m0_ready), 32'd1);
        chk("rs.tie.m0_rdata", m0_rdata, 32'h0BADF00D);
        chk("rs.tie.m1_ready", 32'(m1_ready), 32'd0);
        cyc(); m0v = 0; m1v = 0; srdy = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
